// File: rtl/rggen_apb_bridge_if.sv
// APB bus bundle between the request bridge (master) and a downstream register block (slave).
interface rggen_apb_if #(
   parameter int ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH    = 32
);
   logic                      psel;
   logic                      penable;
   logic [ADDRESS_WIDTH-1:0]  paddr;
   logic                      pwrite;
   logic [DATA_WIDTH-1:0]     pwdata;
   logic [DATA_WIDTH/8-1:0]   pstrb;
   logic                      pready;
   logic [DATA_WIDTH-1:0]     prdata;
   logic                      pslverr;

   modport master (
      output psel, penable, paddr, pwrite, pwdata, pstrb,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  psel, penable, paddr, pwrite, pwdata, pstrb,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/rggen_apb_bridge.sv
// Valid/ready request-response port to APB master bridge, one transfer in flight.
// Optional ACCESS-phase timeout enabled by defining RGGEN_APB_BRIDGE_TIMEOUT_EN.
//
// state       | meaning
// ST_IDLE     | ready for a request, APB idle
// ST_SETUP    | psel=1, penable=0 for one cycle
// ST_ACCESS   | psel=1, penable=1, waiting for pready (or timeout)
// ST_RESPONSE | o_rsp_valid=1 until i_rsp_ready
module rggen_apb_bridge #(
   parameter int ADDRESS_WIDTH  = 16,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_req_valid,
   output logic                      o_req_ready,
   input  logic                      i_req_write,
   input  logic [ADDRESS_WIDTH-1:0]  i_req_address,
   input  logic [DATA_WIDTH-1:0]     i_req_write_data,
   input  logic [DATA_WIDTH/8-1:0]   i_req_strobe,
   output logic                      o_rsp_valid,
   input  logic                      i_rsp_ready,
   output logic [DATA_WIDTH-1:0]     o_rsp_read_data,
   output logic [1:0]                o_rsp_status,
   rggen_apb_if.master               apb_if
);

   localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
   localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = {ADDRESS_WIDTH{1'b1}} << ADDR_LSB;

   localparam logic [1:0] STATUS_OK      = 2'b00;
   localparam logic [1:0] STATUS_SLVERR  = 2'b01;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
   localparam logic [1:0] STATUS_TIMEOUT = 2'b10;
   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
`endif

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESPONSE
   } state_t;

   state_t                     state_q, state_d;
   logic                       write_q, write_d;
   logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
   logic [DATA_WIDTH/8-1:0]    strb_q, strb_d;
   logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
   logic [1:0]                 status_q, status_d;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
   logic [15:0]                cnt_q, cnt_d;
`endif

   always_comb begin
      state_d  = state_q;
      write_d  = write_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      strb_d   = strb_q;
      rdata_d  = rdata_q;
      status_d = status_q;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (i_req_valid) begin
               write_d = i_req_write;
               addr_d  = i_req_address & ADDR_MASK;
               wdata_d = i_req_write_data;
               strb_d  = i_req_strobe;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
            cnt_d   = 16'd1;
`endif
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            // pready in the limit cycle takes priority over the timeout
            if (apb_if.pready) begin
               status_d = apb_if.pslverr ? STATUS_SLVERR : STATUS_OK;
               rdata_d  = write_q ? '0 : apb_if.prdata;
               state_d  = ST_RESPONSE;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
               cnt_d    = '0;
            end else if (cnt_q == TIMEOUT_LIMIT) begin
               status_d = STATUS_TIMEOUT;
               rdata_d  = '0;
               state_d  = ST_RESPONSE;
               cnt_d    = '0;
            end else begin
               cnt_d    = cnt_q + 16'd1;
`endif
            end
         end
         ST_RESPONSE: begin
            if (i_rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         write_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         strb_q   <= '0;
         rdata_q  <= '0;
         status_q <= STATUS_OK;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         strb_q   <= strb_d;
         rdata_q  <= rdata_d;
         status_q <= status_d;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   // ready is gated by rst so it only rises once reset is released
   assign o_req_ready     = (state_q == ST_IDLE) && !rst;
   assign o_rsp_valid     = (state_q == ST_RESPONSE);
   assign o_rsp_read_data = rdata_q;
   assign o_rsp_status    = status_q;

   assign apb_if.psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
   assign apb_if.penable = (state_q == ST_ACCESS);
   assign apb_if.paddr   = addr_q;
   assign apb_if.pwrite  = write_q;
   assign apb_if.pwdata  = wdata_q;
   assign apb_if.pstrb   = write_q ? strb_q : '0;

endmodule

// File: tb/tb_rggen_apb_bridge.sv
// Directed bench for rggen_apb_bridge with an expected-response queue and an inline APB responder.
module tb_rggen_apb_bridge;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req_valid;
   logic          o_req_ready;
   logic          i_req_write;
   logic [AW-1:0] i_req_address;
   logic [DW-1:0] i_req_write_data;
   logic [3:0]    i_req_strobe;
   logic          o_rsp_valid;
   logic          i_rsp_ready;
   logic [DW-1:0] o_rsp_read_data;
   logic [1:0]    o_rsp_status;

   always #5 clk = ~clk;

   rggen_apb_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

   rggen_apb_bridge #(
      .ADDRESS_WIDTH(AW),
      .DATA_WIDTH(DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .i_req_valid      (i_req_valid),
      .o_req_ready      (o_req_ready),
      .i_req_write      (i_req_write),
      .i_req_address    (i_req_address),
      .i_req_write_data (i_req_write_data),
      .i_req_strobe     (i_req_strobe),
      .o_rsp_valid      (o_rsp_valid),
      .i_rsp_ready      (i_rsp_ready),
      .o_rsp_read_data  (o_rsp_read_data),
      .o_rsp_status     (o_rsp_status),
      .apb_if           (apb)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  status;
   } rsp_t;

   rsp_t sb[$];
   int   total  = 0;
   int   passed = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Called at a negedge with the bridge idle; returns at the negedge after the response handshake.
   task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, input int waits, input logic slv,
                         input logic [31:0] rd, input int hold, input logic chain);
      rsp_t        e;
      int          acc_exp;
      int          acc;
      int          cyc;
      logic        to;
      logic [15:0] exp_paddr;
      logic [3:0]  exp_pstrb;
      exp_paddr = addr & 16'hFFFC;
      exp_pstrb = wr ? strb : 4'h0;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
      to = (waits + 1 > TO);
`else
      to = 1'b0;
`endif
      if (to) begin
         e.data   = 32'h0;
         e.status = 2'b10;
         acc_exp  = TO;
      end else begin
         e.data   = wr ? 32'h0 : rd;
         e.status = slv ? 2'b01 : 2'b00;
         acc_exp  = waits + 1;
      end

      chk("req_ready_idle", o_req_ready, 1);
      i_req_valid      = 1'b1;
      i_req_write      = wr;
      i_req_address    = addr;
      i_req_write_data = wd;
      i_req_strobe     = strb;
      sb.push_back(e);
      @(negedge clk);
      i_req_valid = 1'b0;

      chk("setup_psel", apb.psel, 1);
      chk("setup_penable", apb.penable, 0);
      chk("setup_req_ready", o_req_ready, 0);
      chk("setup_apb", {apb.paddr, apb.pwrite, apb.pwdata, apb.pstrb},
          {exp_paddr, wr, wd, exp_pstrb});

      acc = 0;
      cyc = 0;
      @(negedge clk);
      while (apb.psel && apb.penable && cyc < 200) begin
         acc++;
         cyc++;
         chk("access_apb_stable", {apb.paddr, apb.pwrite, apb.pwdata, apb.pstrb},
             {exp_paddr, wr, wd, exp_pstrb});
         if (acc == waits + 1) begin
            apb.pready  = 1'b1;
            apb.prdata  = rd;
            apb.pslverr = slv;
         end else begin
            apb.pready  = 1'b0;
            apb.prdata  = 32'hBAD0_0000 | 32'(acc);
            apb.pslverr = ~slv;
         end
         @(negedge clk);
      end
      apb.pready  = 1'b0;
      apb.pslverr = 1'b0;
      apb.prdata  = 32'h0;
      chk("penable_cycles", 64'(acc), 64'(acc_exp));

      chk("rsp_psel", {apb.psel, apb.penable}, 0);
      for (int h = 0; h < hold; h++) begin
         i_rsp_ready = 1'b0;
         if (chain) i_req_valid = 1'b1;
         chk("hold_rsp_valid", o_rsp_valid, 1);
         chk("hold_rsp", {o_rsp_read_data, o_rsp_status}, {sb[0].data, sb[0].status});
         chk("hold_req_ready", o_req_ready, 0);
         @(negedge clk);
      end
      chk("rsp_valid", o_rsp_valid, 1);
      chk("rsp_data", o_rsp_read_data, sb[0].data);
      chk("rsp_status", o_rsp_status, sb[0].status);
      void'(sb.pop_front());
      i_rsp_ready = 1'b1;
      @(negedge clk);
      i_rsp_ready = 1'b0;
      chk("rsp_valid_drop", o_rsp_valid, 0);
   endtask

   initial begin
      rst              = 1'b1;
      i_req_valid      = 1'b0;
      i_req_write      = 1'b0;
      i_req_address    = '0;
      i_req_write_data = '0;
      i_req_strobe     = '0;
      i_rsp_ready      = 1'b0;
      apb.pready       = 1'b0;
      apb.prdata       = '0;
      apb.pslverr      = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_apb_ctrl", {apb.psel, apb.penable, apb.pwrite}, 0);
      chk("rst_apb_data", {apb.paddr, apb.pwdata, apb.pstrb}, 0);
      chk("rst_rsp", {o_rsp_valid, o_req_ready, o_rsp_read_data, o_rsp_status}, 0);
      rst = 1'b0;
      #1;
      chk("rst_release_ready", o_req_ready, 1);

      // zero-wait read, zero-wait write with address alignment
      do_txn(1'b0, 16'h0004, 32'h0, 4'hF, 0, 1'b0, 32'hDEADBEEF, 0, 1'b0);
      do_txn(1'b1, 16'h0009, 32'h12345678, 4'b0011, 0, 1'b0, 32'hFFFFFFFF, 0, 1'b0);
      // three wait states with slave error
      do_txn(1'b0, 16'h0010, 32'hA5A5A5A5, 4'hF, 3, 1'b1, 32'h55AA55AA, 0, 1'b0);
      // all-zero strobe write, response stalled while a new request waits
      do_txn(1'b1, 16'h0022, 32'h87654321, 4'b0000, 1, 1'b0, 32'h0, 5, 1'b1);
      do_txn(1'b0, 16'h0100, 32'h0, 4'h0, 0, 1'b0, 32'hCAFEF00D, 0, 1'b0);
      // long wait: timeout when enabled, plain wait otherwise; then pready on the limit cycle
      do_txn(1'b0, 16'h0200, 32'h0, 4'h0, 20, 1'b0, 32'h11112222, 0, 1'b0);
      do_txn(1'b0, 16'h0204, 32'h0, 4'h0, TO - 1, 1'b0, 32'h0BADBEEF, 0, 1'b0);
      do_txn(1'b1, 16'h0208, 32'h33334444, 4'hC, 20, 1'b1, 32'h0, 0, 1'b0);

      // reset in the second ACCESS cycle
      chk("mid_req_ready", o_req_ready, 1);
      i_req_valid   = 1'b1;
      i_req_write   = 1'b0;
      i_req_address = 16'h0300;
      @(negedge clk);
      i_req_valid = 1'b0;
      @(negedge clk);
      chk("mid_access1", {apb.psel, apb.penable}, 2'b11);
      @(negedge clk);
      chk("mid_access2", {apb.psel, apb.penable}, 2'b11);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_psel", {apb.psel, apb.penable}, 0);
      chk("mid_rst_rsp_valid", o_rsp_valid, 0);
      chk("mid_rst_req_ready", o_req_ready, 0);
      rst = 1'b0;
      #1;
      chk("mid_release_ready", o_req_ready, 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("mid_no_rsp", {o_rsp_valid, apb.psel}, 0);
      end

      do_txn(1'b0, 16'hFFFF, 32'h0, 4'h0, 0, 1'b0, 32'h01234567, 0, 1'b0);
      chk("sb_empty", 64'(sb.size()), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
